// File: rtl/response_tx_queue.sv
`default_nettype none
// ============================================================================
// Module   : response_tx_queue
// Purpose  : Flow-controlled queue of (response code, response data) byte
//            pairs feeding a UART transmitter. Each pair is sent as two
//            consecutive bytes, code first, through a tx_start / tx_done
//            handshake. Bursts are absorbed while the UART is busy.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   DEPTH        queue capacity in pairs (power of two, >= 2)
//   CW           width of pending_o, equal to log2(DEPTH)+1
// Ports
//   clock_i      system clock, rising edge active
//   reset_n_i    asynchronous active-low reset
//   push_i       enqueue push_code_i / push_data_i this cycle
//   push_code_i  response code byte
//   push_data_i  response data byte
//   full_o       queue holds DEPTH pairs
//   pending_o    pairs held, including the pair currently being sent
//   overflow_o   sticky flag, set when a push is rejected (cleared by reset)
//   tx_busy_i    UART transmitter busy
//   tx_done_i    one-cycle pulse, UART finished a byte
//   tx_start_o   one-cycle pulse requesting transmission of tx_byte_o
//   tx_byte_o    byte to transmit, held until the next tx_start_o
// ============================================================================
module response_tx_queue #(
    parameter int DEPTH = 4,
    parameter int CW    = 3
) (
    input  logic          clock_i,
    input  logic          reset_n_i,
    input  logic          push_i,
    input  logic [7:0]    push_code_i,
    input  logic [7:0]    push_data_i,
    output logic          full_o,
    output logic [CW-1:0] pending_o,
    output logic          overflow_o,
    input  logic          tx_busy_i,
    input  logic          tx_done_i,
    output logic          tx_start_o,
    output logic [7:0]    tx_byte_o
);

    localparam int            c_aw         = $clog2(DEPTH);
    localparam logic [CW-1:0] c_full_count = CW'(DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WAIT_CODE = 2'd1,
        ST_SEND_DATA = 2'd2,
        ST_WAIT_DATA = 2'd3
    } state_t;

    state_t            state_q,    state_d;
    logic [c_aw-1:0]   rd_ptr_q,   rd_ptr_d;
    logic [c_aw-1:0]   wr_ptr_q,   wr_ptr_d;
    logic [CW-1:0]     count_q,    count_d;
    logic              overflow_q, overflow_d;
    logic              tx_start_q, tx_start_d;
    logic [7:0]        tx_byte_q,  tx_byte_d;

    // Pair storage, {code, data} per entry.
    logic [15:0]       mem_q [DEPTH];

    logic              w_full;
    logic              w_push_ok;
    logic              w_pop;
    logic [15:0]       w_head;

    // ------------------------------------------------------------------------
    // Queue bookkeeping
    // ------------------------------------------------------------------------
    assign w_full    = (count_q == c_full_count);
    assign w_push_ok = push_i && !w_full;
    // The head stays in the queue for the whole pair; it leaves only when the
    // UART reports the end of its data byte.
    assign w_pop     = (state_q == ST_WAIT_DATA) && tx_done_i;
    assign w_head    = mem_q[rd_ptr_q];

    always_comb begin
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        count_d    = count_q;
        // A push against a full queue is rejected even if the head pops in
        // the same cycle: fullness is judged on the registered count.
        overflow_d = overflow_q | (push_i & w_full);

        if (w_push_ok) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (w_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end

        case ({w_push_ok, w_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Storage array carries no reset; entries are only read once the
    // occupancy counter says they were written.
    always_ff @(posedge clock_i) begin
        if (w_push_ok) begin
            mem_q[wr_ptr_q] <= {push_code_i, push_data_i};
        end
    end

    // ------------------------------------------------------------------------
    // Transmit sequencer
    // ------------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        tx_start_d = 1'b0;
        tx_byte_d  = tx_byte_q;

        case (state_q)
            ST_IDLE: begin
                if ((count_q != '0) && !tx_busy_i) begin
                    tx_start_d = 1'b1;
                    tx_byte_d  = w_head[15:8];
                    state_d    = ST_WAIT_CODE;
                end
            end
            ST_WAIT_CODE: begin
                if (tx_done_i) begin
                    state_d = ST_SEND_DATA;
                end
            end
            ST_SEND_DATA: begin
                if (!tx_busy_i) begin
                    tx_start_d = 1'b1;
                    tx_byte_d  = w_head[7:0];
                    state_d    = ST_WAIT_DATA;
                end
            end
            ST_WAIT_DATA: begin
                if (tx_done_i) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q    <= ST_IDLE;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            tx_start_q <= 1'b0;
            tx_byte_q  <= 8'h00;
        end else begin
            state_q    <= state_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            tx_start_q <= tx_start_d;
            tx_byte_q  <= tx_byte_d;
        end
    end

    assign full_o     = w_full;
    assign pending_o  = count_q;
    assign overflow_o = overflow_q;
    assign tx_start_o = tx_start_q;
    assign tx_byte_o  = tx_byte_q;

endmodule
`default_nettype wire

// File: tb/tb_response_tx_queue.sv
`default_nettype none
// ============================================================================
// Module   : tb_response_tx_queue
// Purpose  : Self-checking bench for response_tx_queue. A UART stand-in
//            answers tx_start with a busy period and a tx_done pulse; a
//            reference model (pair count, byte stream queue, overflow flag)
//            predicts every output after every clock edge.
// Revision : 1.0 - initial release
// ============================================================================
module tb_response_tx_queue;

    localparam int DEPTH = 4;
    localparam int CW    = 3;

    logic          clock     = 1'b0;
    logic          reset_n   = 1'b0;
    logic          push      = 1'b0;
    logic [7:0]    push_code = 8'h00;
    logic [7:0]    push_data = 8'h00;
    logic          full;
    logic [CW-1:0] pending;
    logic          overflow;
    logic          tx_busy   = 1'b0;
    logic          tx_done   = 1'b0;
    logic          tx_start;
    logic [7:0]    tx_byte;

    always #5 clock = ~clock;

    response_tx_queue #(.DEPTH(DEPTH), .CW(CW)) dut (
        .clock_i     (clock),
        .reset_n_i   (reset_n),
        .push_i      (push),
        .push_code_i (push_code),
        .push_data_i (push_data),
        .full_o      (full),
        .pending_o   (pending),
        .overflow_o  (overflow),
        .tx_busy_i   (tx_busy),
        .tx_done_i   (tx_done),
        .tx_start_o  (tx_start),
        .tx_byte_o   (tx_byte)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: actual 0x%0h, required 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ------------------------------------------------------------------------
    // Reference model: pairs held, bytes still to be sent in order, whether a
    // byte is on the wire, and whether a pair has its code sent but not yet
    // its data.
    // ------------------------------------------------------------------------
    int         m_count = 0;
    bit         m_ovf   = 0;
    bit         m_outst = 0;
    bit         m_mid   = 0;
    bit         m_start = 0;
    logic [7:0] m_byte  = 8'h00;
    logic [7:0] m_bytes [$];
    int         m_pre;
    bit         m_acc;
    bit         m_pop;

    logic [7:0] tx_log [$];
    int         tx_cyc [$];

    always begin
        @(posedge clock);
        cyc++;
        if (!reset_n) begin
            m_count = 0; m_ovf = 0; m_outst = 0; m_mid = 0;
            m_start = 0; m_byte = 8'h00;
            m_bytes.delete();
        end else begin
            m_pre   = m_count;
            // Next byte goes out when nothing is on the wire, the UART is free,
            // and there is either a pending data byte or a fresh pair.
            m_start = !m_outst && !tx_busy && (m_mid || m_pre != 0);
            m_pop   = tx_done && m_outst && !m_mid;
            if (tx_done && m_outst) m_outst = 0;
            if (m_start) begin
                m_outst = 1;
                m_mid   = !m_mid;
                if (m_bytes.size() == 0) begin
                    chk("model_byte_underflow", 32'd1, 32'd0);
                    m_byte = 8'h00;
                end else begin
                    m_byte = m_bytes.pop_front();
                end
            end
            m_acc = push && (m_pre != DEPTH);
            if (push && !m_acc) m_ovf = 1;
            if (m_acc) begin
                m_bytes.push_back(push_code);
                m_bytes.push_back(push_data);
            end
            m_count = m_pre + int'(m_acc) - int'(m_pop);
        end
        #1;
        chk("pending",  32'(pending),  32'(m_count));
        chk("full",     32'(full),     32'(m_count == DEPTH));
        chk("overflow", 32'(overflow), 32'(m_ovf));
        chk("tx_start", 32'(tx_start), 32'(m_start));
        chk("tx_byte",  32'(tx_byte),  32'(m_byte));
        if (tx_start === 1'b1) begin
            tx_log.push_back(tx_byte);
            tx_cyc.push_back(cyc);
        end
    end

    // ------------------------------------------------------------------------
    // UART stand-in, driven on the falling edge.
    // ------------------------------------------------------------------------
    int uart_len   = 4;
    bit hold_busy  = 0;
    bit spur_en    = 0;
    int stall_next = 0;
    bit inject     = 0;
    bit inj_active = 0;
    bit u_act = 0, u_code = 0, u_par = 0;
    int u_cnt = 0, hold_cnt = 0;

    always @(negedge clock) begin
        if (!reset_n) begin
            u_act = 0; u_par = 0; hold_cnt = 0; tx_done = 0;
            if (inj_active) begin push = 0; inj_active = 0; end
            tx_busy = hold_busy;
        end else begin
            tx_done = 0;
            if (inj_active) begin push = 0; inj_active = 0; end
            if (hold_cnt > 0) hold_cnt--;
            if (u_act) begin
                if (u_cnt == 0) begin
                    tx_done = 1;
                    u_act   = 0;
                    if (u_code && stall_next > 0) begin
                        hold_cnt   = stall_next;
                        stall_next = 0;
                    end
                    if (!u_code && inject) begin
                        push = 1; push_code = 8'hEE; push_data = 8'hEF;
                        inject = 0; inj_active = 1;
                    end
                end else begin
                    u_cnt--;
                end
            end else if (tx_start) begin
                u_act  = 1;
                u_cnt  = uart_len;
                u_code = !u_par;
                u_par  = !u_par;
            end else if (spur_en && $urandom_range(0, 7) == 0) begin
                tx_done = 1;
            end
            tx_busy = u_act || hold_busy || (hold_cnt > 0);
        end
    end

    // ------------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------------
    task automatic do_reset();
        @(negedge clock);
        reset_n = 0;
        push    = 0;
        repeat (2) @(negedge clock);
        reset_n = 1;
    endtask

    task automatic push_run(input int n, input logic [7:0] cbase, input logic [7:0] dbase);
        for (int i = 0; i < n; i++) begin
            @(negedge clock);
            push = 1; push_code = cbase + 8'(i); push_data = dbase + 8'(i);
        end
        @(negedge clock);
        push = 0;
    endtask

    task automatic wait_idle(input int budget);
        int k;
        k = 0;
        while (!(m_count == 0 && !m_outst && !m_mid) && k < budget) begin
            @(negedge clock);
            k++;
        end
        if (k >= budget) chk("drain_timeout", 32'd1, 32'd0);
    endtask

    task automatic wait_log(input int n, input int budget);
        int k;
        k = 0;
        while (tx_log.size() < n && k < budget) begin
            @(negedge clock);
            k++;
        end
        if (k >= budget) chk("tx_start_timeout", 32'd1, 32'd0);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog expired");
    end

    int pc;
    int nb;

    initial begin
        repeat (2) @(negedge clock);
        chk("reset_pending",  32'(pending),  32'd0);
        chk("reset_tx_byte",  32'(tx_byte),  32'h00);
        chk("reset_tx_start", 32'(tx_start), 32'd0);
        reset_n = 1;

        // Single pair, 10-cycle busy per byte.
        uart_len = 9;
        tx_log.delete(); tx_cyc.delete();
        @(negedge clock);
        pc = cyc;
        push = 1; push_code = 8'hA1; push_data = 8'h2F;
        @(negedge clock);
        push = 0;
        wait_idle(300);
        chk("single_count", 32'(tx_log.size()), 32'd2);
        if (tx_log.size() >= 2) begin
            chk("single_code",     32'(tx_log[0]), 32'hA1);
            chk("single_data",     32'(tx_log[1]), 32'h2F);
            chk("single_code_lat", 32'(tx_cyc[0] - pc), 32'd2);
            chk("single_data_gap", 32'(tx_cyc[1] - tx_cyc[0]), 32'd12);
        end
        chk("single_pending", 32'(pending),  32'd0);
        chk("single_ovf",     32'(overflow), 32'd0);

        // Burst fill against a held-busy UART.
        do_reset();
        uart_len = 4; hold_busy = 1;
        tx_log.delete(); tx_cyc.delete();
        push_run(5, 8'h10, 8'h80);
        chk("burst_full",    32'(full),     32'd1);
        chk("burst_ovf",     32'(overflow), 32'd1);
        chk("burst_pending", 32'(pending),  32'd4);
        hold_busy = 0;
        wait_idle(400);
        chk("burst_count", 32'(tx_log.size()), 32'd8);
        for (int i = 0; i < 8 && i < tx_log.size(); i++) begin
            chk("burst_byte", 32'(tx_log[i]), (i % 2 == 0) ? 32'h10 + 32'(i / 2) : 32'h80 + 32'(i / 2));
        end

        // Push while full in the same cycle as the head's data-byte tx_done.
        do_reset();
        hold_busy = 1;
        tx_log.delete(); tx_cyc.delete();
        push_run(4, 8'h20, 8'h90);
        inject = 1;
        hold_busy = 0;
        nb = 0;
        while (inject && nb < 200) begin @(negedge clock); nb++; end
        if (nb >= 200) chk("inject_timeout", 32'd1, 32'd0);
        @(posedge clock); #2;
        chk("fullpop_ovf",     32'(overflow), 32'd1);
        chk("fullpop_pending", 32'(pending),  32'd3);
        chk("fullpop_full",    32'(full),     32'd0);
        wait_idle(400);
        chk("fullpop_count", 32'(tx_log.size()), 32'd8);
        if (tx_log.size() >= 8) chk("fullpop_last", 32'(tx_log[7]), 32'h93);

        // Reset in the middle of the data byte.
        tx_log.delete(); tx_cyc.delete();
        push_run(1, 8'h5A, 8'hC3);
        wait_log(2, 100);
        @(negedge clock);
        reset_n = 0;
        #1;
        chk("rst_tx_start", 32'(tx_start), 32'd0);
        chk("rst_tx_byte",  32'(tx_byte),  32'h00);
        chk("rst_pending",  32'(pending),  32'd0);
        chk("rst_ovf",      32'(overflow), 32'd0);
        repeat (2) @(negedge clock);
        reset_n = 1;
        tx_log.delete(); tx_cyc.delete();
        push_run(1, 8'h66, 8'h99);
        wait_idle(200);
        chk("post_rst_count", 32'(tx_log.size()), 32'd2);
        if (tx_log.size() >= 2) begin
            chk("post_rst_code", 32'(tx_log[0]), 32'h66);
            chk("post_rst_data", 32'(tx_log[1]), 32'h99);
        end

        // Busy held 20 cycles after the code byte completes.
        tx_log.delete(); tx_cyc.delete();
        stall_next = 20;
        push_run(1, 8'h3C, 8'hD2);
        wait_idle(300);
        chk("stall_count", 32'(tx_log.size()), 32'd2);
        if (tx_log.size() >= 2) begin
            chk("stall_data", 32'(tx_log[1]), 32'hD2);
            chk("stall_gap",  32'(tx_cyc[1] - tx_cyc[0]), 32'd26);
        end

        // Wrap-around: 10 pairs in groups of 3 while draining.
        uart_len = 1;
        tx_log.delete(); tx_cyc.delete();
        for (int g = 0; g < 4; g++) begin
            push_run((g == 3) ? 1 : 3, 8'h40 + 8'(3 * g), 8'hB0 + 8'(3 * g));
            repeat (25) @(negedge clock);
        end
        wait_idle(400);
        chk("wrap_count", 32'(tx_log.size()), 32'd20);
        for (int i = 0; i < 20 && i < tx_log.size(); i++) begin
            chk("wrap_byte", 32'(tx_log[i]), (i % 2 == 0) ? 32'h40 + 32'(i / 2) : 32'hB0 + 32'(i / 2));
        end
        chk("wrap_pending", 32'(pending),  32'd0);
        chk("wrap_ovf",     32'(overflow), 32'd0);

        // Randomised traffic with spurious tx_done and occasional resets.
        spur_en = 1;
        for (int i = 0; i < 4000; i++) begin
            if (i % 1000 == 999) begin
                do_reset();
            end else begin
                @(negedge clock);
                push      = ($urandom_range(0, 99) < 30);
                push_code = 8'($urandom);
                push_data = 8'($urandom);
                if (i % 50 == 0) begin
                    uart_len  = $urandom_range(0, 5);
                    hold_busy = ($urandom_range(0, 3) == 0);
                end
            end
        end
        @(negedge clock);
        push = 0; hold_busy = 0; spur_en = 0;
        wait_idle(2000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/response_tx_queue.md
# response_tx_queue

Buffers decoded sensor responses, each a (response code, response data) byte pair, and serialises them to the UART transmitter as two consecutive bytes, code first. It sits between the sensor decode/response path and `UART_TX`. It absorbs bursts of responses while the UART is busy and drives the transmitter through a start/done handshake. It replaces ad-hoc back-to-back byte presentation with a flow-controlled queue.

## Interface
- `DEPTH`, default 4: queue capacity in pairs; power of two, ≥ 2.
- `CW`, default 3: width of `pending`; must equal log2(`DEPTH`)+1.

Ports:
- `clock`  in  1: system clock; all state changes on rising edge.
- `reset_n`  in  1: reset, asynchronous and active-low.
- `push`  in  1: enqueue `push_code`/`push_data` this cycle.
- `push_code`  in  8: response code byte.
- `push_data`  in  8: response data byte.
- `full`  out  1: `pending == DEPTH`.
- `pending`  out  CW: pairs held, including the pair in flight.
- `overflow`  out  1: sticky; set when a push is rejected.
- `tx_busy`  in  1: UART_TX is transmitting.
- `tx_done`  in  1: one-cycle pulse, byte transmission finished.
- `tx_start`  out  1: one-cycle pulse requesting transmission of `tx_byte`.
- `tx_byte`  out  8: byte to transmit; stable from `tx_start` until the next `tx_start`.

## Operation
- Storage: circular buffer of `DEPTH` 16-bit entries {code,data}; read and write pointers of log2(`DEPTH`) bits, wrap modulo `DEPTH`; separate occupancy counter drives `pending`/`full`.
- Push: accepted when `push` && !`full`; written at the write pointer, which then increments.
- Push while `full` is rejected and sets `overflow`, even if a pop occurs in the same cycle. `overflow` clears only on reset.
- Pop: head entry is removed only on the `tx_done` that ends its data byte. Simultaneous accepted push and pop leaves `pending` unchanged.
- FSM states:
  - IDLE: if `pending` ≠ 0 and !`tx_busy`: `tx_start`←1, `tx_byte`←head code, go to WAIT_CODE.
  - WAIT_CODE: on `tx_done`, go to SEND_DATA.
  - SEND_DATA: when !`tx_busy`: `tx_start`←1, `tx_byte`←head data, go to WAIT_DATA.
  - WAIT_DATA: on `tx_done`, pop the head and go to IDLE.
- `tx_start` defaults to 0 every cycle it is not explicitly set.
- `tx_done` in IDLE or SEND_DATA is ignored.
- `tx_busy` is not checked in the WAIT states.
- A pair is never split or reordered. The code byte of pair N+1 never precedes the data byte of pair N.
- Unreachable state encodings return to IDLE with `tx_start`=0.

## Timing
- Reset (async assert, any time): pointers, counter, `pending`=0, `full`=0, `overflow`=0, `tx_start`=0, `tx_byte`=0x00, state IDLE. An in-flight pair is discarded.
- Latency: `push` sampled at edge 0 into an empty, idle queue with `tx_busy`=0 gives `pending`=1 after edge 0 and `tx_start`=1 with `tx_byte`=code after edge 1.
- After the `tx_done` of the code byte is sampled (edge k), state is SEND_DATA. `tx_start` for data is asserted after edge k+1 if `tx_busy`=0 at that edge, otherwise later.
- After the `tx_done` of the data byte is sampled at edge m: `pending` decrements after edge m. The next pair's `tx_start` is no earlier than after edge m+1.
- `full` and `pending` are registered and update on the edge after the push/pop.

## Test plan
- Single pair: push (0xA1,0x2F); model UART with 10-cycle busy.
  - -> `tx_start` two cycles after push with 0xA1, then `tx_start` with 0x2F.
  - -> `pending` 1→0 after the second `tx_done`; `overflow`=0.
- Burst fill: 5 back-to-back pushes with `DEPTH`=4 and `tx_busy` held high.
  - -> `full`=1 after the 4th push; 5th rejected; `overflow`=1.
  - -> on release, 8 bytes emitted in order, codes and data interleaved.
- Full with simultaneous pop: push during the data-byte `tx_done` cycle while `full`.
  - -> push rejected, `overflow`=1, `pending`=3 afterwards.
- Busy stall: `tx_busy` high for 20 cycles after the code byte's `tx_done`.
  - -> no `tx_start` until `tx_busy` falls, then `tx_start` on the next cycle with the data byte.
- Wrap-around: 10 pairs pushed in groups of 3 while draining.
  - -> all 20 bytes correct and in order; pointers wrap; `pending` returns to 0.
- Reset mid-transfer: assert `reset_n`=0 in WAIT_DATA.
  - -> immediately `tx_start`=0, `tx_byte`=0x00, `pending`=0, `overflow`=0.
  - -> after release, a new push transmits normally.
